// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared types and the access-alignment rule for the data port.
// Revision    : 1.0
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_BYTE = 2'b00,
        ST_HALF = 2'b01,
        ST_WORD = 2'b10,
        ST_ILL  = 2'b11
    } storetype_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Loads and stores share this rule; ST_ILL is always an error.
    function automatic logic align_err(input logic [1:0] addr, input storetype_e storetype);
        logic r;
        case (storetype)
            ST_BYTE: r = 1'b0;
            ST_HALF: r = addr[0];
            ST_WORD: r = (addr != 2'b00);
            default: r = 1'b1;
        endcase
        align_err = r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_gen.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_gen
// Description : Byte-enable and lane-replicated write data for 32-bit stores.
// Revision    : 1.0
// ============================================================================
module dmem_lane_gen
    import riscv_mem_pkg::*;
#(
    parameter int N_Bits = 32
) (
    input  logic [1:0]        i_addr_lo,
    input  logic [1:0]        i_storetype,
    input  logic [N_Bits-1:0] i_wd,
    output logic [3:0]        o_be,
    output logic [N_Bits-1:0] o_wdata
);

    // Data is replicated into every lane; the enables pick the lanes written.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wd;
        case (storetype_e'(i_storetype))
            ST_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {(N_Bits/8){i_wd[7:0]}};
            end
            ST_HALF: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {(N_Bits/16){i_wd[15:0]}};
            end
            ST_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wd;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = i_wd;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder with wait states, byte lanes and checks.
// Revision    : 1.0
// ============================================================================
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int N_Bits      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N_Bits-1:0] A,
    input  logic              WE,
    input  logic [1:0]        Storetype,
    input  logic [N_Bits-1:0] WD,
    output logic [N_Bits-1:0] RD,
    output logic              rsp_valid,
    output logic              rsp_err
);

    localparam int              c_aw       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [N_Bits-3:0] c_depth  = (N_Bits-2)'(DEPTH_WORDS);
    localparam logic [3:0]      c_cnt_init = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    dmem_state_e       r_state;
    dmem_state_e       w_next;
    logic [3:0]        r_cnt;
    logic [c_aw-1:0]   r_idx;
    logic              r_we;
    logic              r_err;
    logic [3:0]        r_be;
    logic [N_Bits-1:0] r_wdata;
    logic [N_Bits-1:0] r_rd;
    logic              r_rsp_err;
    logic [N_Bits-1:0] r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_req_err;
    logic [3:0]        w_be;
    logic [N_Bits-1:0] w_wdata;
    logic [c_aw-1:0]   w_idx;
    logic              w_access;
    logic              w_wr;
    logic [c_aw-1:0]   w_acc_idx;
    logic              w_acc_we;
    logic              w_acc_err;
    logic [3:0]        w_acc_be;
    logic [N_Bits-1:0] w_acc_wdata;

    dmem_lane_gen #(
        .N_Bits (N_Bits)
    ) u_lane_gen (
        .i_addr_lo   (A[1:0]),
        .i_storetype (Storetype),
        .i_wd        (WD),
        .o_be        (w_be),
        .o_wdata     (w_wdata)
    );

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_req_err = align_err(A[1:0], storetype_e'(Storetype)) || (A[N_Bits-1:2] >= c_depth);
    assign w_idx     = A[c_aw+1:2];

    // With zero wait states the access happens on the accept edge, so the
    // live request is used instead of the capture registers.
    assign w_acc_idx   = (r_state == IDLE) ? w_idx     : r_idx;
    assign w_acc_we    = (r_state == IDLE) ? WE        : r_we;
    assign w_acc_err   = (r_state == IDLE) ? w_req_err : r_err;
    assign w_acc_be    = (r_state == IDLE) ? w_be      : r_be;
    assign w_acc_wdata = (r_state == IDLE) ? w_wdata   : r_wdata;

    assign w_access = (w_next == RESP) && (r_state != RESP);
    assign w_wr     = rst && w_access && w_acc_we && !w_acc_err;

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_be      <= 4'b0000;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_we    <= WE;
                r_err   <= w_req_err;
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_cnt   <= c_cnt_init;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rsp_err <= w_acc_err;
                r_rd      <= (!w_acc_we && !w_acc_err) ? r_mem[w_acc_idx] : '0;
            end
        end
    end

    // RAM contents survive reset; only the write strobe is reset-qualified.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_wr && w_acc_be[i]) begin
                r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
        end
    end

    assign RD      = r_rd;
    assign rsp_err = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench for dmem_responder at 1 and 3 wait states.
// Revision    : 1.0
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] a_s       [2];
    logic        we_s      [2];
    logic [1:0]  st_s      [2];
    logic [31:0] wd_s      [2];
    logic [31:0] rd_s      [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.N_Bits(32), .DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .A(a_s[0]), .WE(we_s[0]), .Storetype(st_s[0]), .WD(wd_s[0]),
        .RD(rd_s[0]), .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.N_Bits(32), .DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .A(a_s[1]), .WE(we_s[1]), .Storetype(st_s[1]), .WD(wd_s[1]),
        .RD(rd_s[1]), .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1])
    );

    // One request on instance k; returns the response and its latency in
    // cycles after the accept edge (0 if no response arrived).
    task automatic do_req(input int k, input logic [31:0] addr, input logic we,
                          input logic [1:0] st, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int guard;
        a_s[k] = addr; we_s[k] = we; st_s[k] = st; wd_s[k] = wd;
        req_valid[k] = 1'b1;
        guard = 0;
        while (!req_ready[k] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 0; rd = 32'h0; err = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (rsp_valid[k]) begin
                lat = c; rd = rd_s[k]; err = rsp_err[k];
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (req_ready[k] !== 1'b1) $display("FAIL rst_ready[%0d]: got %b want 1", k, req_ready[k]); else n_pass++;
            n_checks++; if (rsp_valid[k] !== 1'b0) $display("FAIL rst_rsp_valid[%0d]: got %b want 0", k, rsp_valid[k]); else n_pass++;
            n_checks++; if (rsp_err[k] !== 1'b0) $display("FAIL rst_rsp_err[%0d]: got %b want 0", k, rsp_err[k]); else n_pass++;
            n_checks++; if (rd_s[k] !== 32'h0) $display("FAIL rst_rd[%0d]: got %h want 00000000", k, rd_s[k]); else n_pass++;
        end
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] rd; logic err; int lat;
        do_req(0, 32'h10, 1'b1, 2'b10, 32'hDEADBEEF, rd, err, lat);
        n_checks++; if (lat !== 2) $display("FAIL wr_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL wr_err: got %b want 0", err); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL wr_rd: got %h want 00000000", rd); else n_pass++;
        do_req(0, 32'h10, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (lat !== 2) $display("FAIL rd_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rd_err: got %b want 0", err); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else n_pass++;
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic err; int lat;
        do_req(0, 32'h20, 1'b1, 2'b10, 32'h00000000, rd, err, lat);
        do_req(0, 32'h22, 1'b1, 2'b00, 32'h123456AB, rd, err, lat);
        n_checks++; if (err !== 1'b0) $display("FAIL byte_err: got %b want 0", err); else n_pass++;
        do_req(0, 32'h20, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (rd !== 32'h00AB0000) $display("FAIL byte_merge: got %h want 00ab0000", rd); else n_pass++;
        do_req(0, 32'h24, 1'b1, 2'b10, 32'h11111111, rd, err, lat);
        do_req(0, 32'h26, 1'b1, 2'b01, 32'hFFFFBEEF, rd, err, lat);
        do_req(0, 32'h24, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (rd !== 32'hBEEF1111) $display("FAIL half_merge: got %h want beef1111", rd); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat;
        do_req(0, 32'h21, 1'b1, 2'b01, 32'hFFFFFFFF, rd, err, lat);
        n_checks++; if (err !== 1'b1) $display("FAIL half_misalign_err: got %b want 1", err); else n_pass++;
        do_req(0, 32'h20, 1'b1, 2'b11, 32'hFFFFFFFF, rd, err, lat);
        n_checks++; if (err !== 1'b1) $display("FAIL illegal_st_err: got %b want 1", err); else n_pass++;
        do_req(0, 32'h20, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (rd !== 32'h00AB0000) $display("FAIL err_no_write: got %h want 00ab0000", rd); else n_pass++;
        do_req(0, 32'h22, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL word_misalign_load: got err=%b rd=%h want err=1 rd=00000000", err, rd); else n_pass++;
        do_req(0, 32'h20, 1'b0, 2'b11, 32'h0, rd, err, lat);
        n_checks++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL illegal_load: got err=%b rd=%h want err=1 rd=00000000", err, rd); else n_pass++;
        do_req(0, 32'h0, 1'b1, 2'b10, 32'h01020304, rd, err, lat);
        do_req(0, 32'h400, 1'b1, 2'b10, 32'hFFFFFFFF, rd, err, lat);
        n_checks++; if (err !== 1'b1) $display("FAIL range_store_err: got %b want 1", err); else n_pass++;
        do_req(0, 32'h400, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL range_load: got err=%b rd=%h want err=1 rd=00000000", err, rd); else n_pass++;
        do_req(0, 32'h0, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (rd !== 32'h01020304) $display("FAIL range_no_alias: got %h want 01020304", rd); else n_pass++;
        do_req(0, 32'h3FC, 1'b1, 2'b10, 32'hCAFEF00D, rd, err, lat);
        n_checks++; if (err !== 1'b0) $display("FAIL top_word_err: got %b want 0", err); else n_pass++;
        do_req(0, 32'h3FC, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL top_word_rd: got %h want cafef00d", rd); else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int lat;
        logic [4:0]  ready_pat;
        logic [4:0]  rsp_pat;
        int          guard;
        int          extra_rsp;
        do_req(1, 32'h40, 1'b1, 2'b10, 32'h5A5AA5A5, rd, err, lat);
        n_checks++; if (lat !== 4) $display("FAIL ws3_latency: got %0d want 4", lat); else n_pass++;
        // Hold the load request through WAIT; only one response may come back.
        a_s[1] = 32'h40; we_s[1] = 1'b0; st_s[1] = 2'b10; wd_s[1] = 32'h0;
        req_valid[1] = 1'b1;
        guard = 0;
        while (!req_ready[1] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        ready_pat = '0; rsp_pat = '0; rd = 32'h0;
        for (int c = 0; c < 5; c++) begin
            ready_pat[c] = req_ready[1];
            rsp_pat[c]   = rsp_valid[1];
            if (rsp_valid[1]) rd = rd_s[1];
            if (c == 4) req_valid[1] = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++; if (ready_pat !== 5'b10000) $display("FAIL ws3_ready_pattern: got %b want 10000", ready_pat); else n_pass++;
        n_checks++; if (rsp_pat !== 5'b01000) $display("FAIL ws3_rsp_pattern: got %b want 01000", rsp_pat); else n_pass++;
        n_checks++; if (rd !== 32'h5A5AA5A5) $display("FAIL ws3_rd: got %h want 5a5aa5a5", rd); else n_pass++;
        extra_rsp = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid[1]) extra_rsp++;
            @(posedge clk); #1;
        end
        n_checks++; if (extra_rsp !== 0) $display("FAIL ws3_no_double_accept: got %0d want 0", extra_rsp); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic err; int lat;
        int guard;
        do_req(1, 32'h30, 1'b1, 2'b10, 32'hAAAA5555, rd, err, lat);
        do_req(1, 32'h30, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (rd !== 32'hAAAA5555) $display("FAIL pre_reset_rd: got %h want aaaa5555", rd); else n_pass++;
        a_s[1] = 32'h30; we_s[1] = 1'b1; st_s[1] = 2'b10; wd_s[1] = 32'h12345678;
        req_valid[1] = 1'b1;
        guard = 0;
        while (!req_ready[1] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (req_ready[1] !== 1'b0) $display("FAIL in_wait_ready: got %b want 0", req_ready[1]); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_err[1] !== 1'b0 || rd_s[1] !== 32'h0)
            $display("FAIL async_reset: got ready=%b rsp_valid=%b rsp_err=%b rd=%h want 1 0 0 00000000",
                     req_ready[1], rsp_valid[1], rsp_err[1], rd_s[1]);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        do_req(1, 32'h30, 1'b0, 2'b10, 32'h0, rd, err, lat);
        n_checks++; if (rd !== 32'hAAAA5555) $display("FAIL reset_abandons_store: got %h want aaaa5555", rd); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; a_s[k] = 32'h0; we_s[k] = 1'b0; st_s[k] = 2'b00; wd_s[k] = 32'h0;
        end
        #1 rst = 1'b0;
        #1;
        test_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        test_word_roundtrip();
        test_lanes();
        test_errors();
        test_wait_states();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
